// File: rtl/square_fixed_shift_add.sv
// Iterative shift-add squarer: out = floor(in*in / 2^(2*FRAC)), one partial product per clock.
// Define ROUND_EN to round half-up at finalize instead of truncating.
module square_fixed_shift_add #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in,
  input  logic             START,
  output logic [WIDTH-1:0] out,
  output logic             DONE,
  output logic             AVAILABLE
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [AW-1:0]   acc, acc_n;
  logic [CW-1:0]   cntr, cntr_n;
  logic [WIDTH-1:0] out_n;
  logic [AW:0]     sum;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cntr   <= '0;
      out    <= '0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cntr   <= cntr_n;
      out    <= out_n;
    end
  end

  // Extra top bit keeps the rounding add from wrapping when FRAC == WIDTH.
  always_comb begin
`ifdef ROUND_EN
    sum = {1'b0, acc} + ((AW + 1)'(1) << (2 * FRAC - 1));
`else
    sum = {1'b0, acc};
`endif
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cntr_n   = cntr;
    out_n    = out;
    unique case (state)
      IDLE: begin
        if (START) begin
          mcand_n  = {{WIDTH{1'b0}}, in};
          mplier_n = in;
          acc_n    = '0;
          cntr_n   = '0;
          state_n  = CALC;
        end
      end
      CALC: begin
        if (cntr == LAST) begin
          out_n   = WIDTH'(sum >> (2 * FRAC));
          cntr_n  = '0;
          state_n = HOLD;
        end else begin
          if (mplier[0]) acc_n = acc + mcand;
          mcand_n  = mcand << 1;
          mplier_n = mplier >> 1;
          cntr_n   = cntr + 1'b1;
        end
      end
      HOLD: begin
        if (!START) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign DONE      = (state == HOLD);
  assign AVAILABLE = (state == IDLE);

endmodule

// File: tb/tb_square_fixed_shift_add.sv
// Bench for square_fixed_shift_add: directed and random operands against an
// arithmetic squaring model, plus handshake, latency and reset-abort checks.
module tb_square_fixed_shift_add;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] in;
  logic        START;
  logic [31:0] out;
  logic        DONE;
  logic        AVAILABLE;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp;

  square_fixed_shift_add #(.WIDTH(32), .FRAC(16)) dut (
    .clk(clk),
    .rstn(rstn),
    .in(in),
    .START(START),
    .out(out),
    .DONE(DONE),
    .AVAILABLE(AVAILABLE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v);
    logic [64:0] p;
    p = 65'(v) * 65'(v);
`ifdef ROUND_EN
    p = p + (65'(1) << 31);
`endif
    return 32'(p >> 32);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] v, input bit scramble,
                        input int hold);
    int n;
    logic [31:0] exp;
    exp = model(v);
    n = 0;
    while (!AVAILABLE && n < 50) begin
      tick();
      n++;
    end
    chk("avail_before_start", 64'(AVAILABLE), 64'd1);
    in = v;
    START = 1'b1;
    tick();
    chk("avail_after_accept", 64'(AVAILABLE), 64'd0);
    chk("done_after_accept", 64'(DONE), 64'd0);
    chk("out_held_calc", 64'(out), 64'(last_exp));
    n = 0;
    while (!DONE && n < 100) begin
      if (scramble) begin
        in = $urandom;
        START = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd33);
    chk("result", 64'(out), 64'(exp));
    last_exp = exp;
    START = 1'b1;
    for (int k = 0; k < hold; k++) begin
      in = $urandom;
      tick();
      chk("hold_done", 64'(DONE), 64'd1);
      chk("hold_out", 64'(out), 64'(exp));
    end
    START = 1'b0;
    tick();
    chk("drop_done", 64'(DONE), 64'd0);
    chk("drop_avail", 64'(AVAILABLE), 64'd1);
    chk("idle_out", 64'(out), 64'(exp));
  endtask

  initial begin
    rstn = 1'b1;
    START = 1'b0;
    in = '0;
    last_exp = '0;
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_avail", 64'(AVAILABLE), 64'd1);

    run_op(32'h0003_0000, 1'b0, 0);
    chk("lit_3p0", 64'(out), 64'd9);
    run_op(32'h0001_4000, 1'b0, 0);
`ifdef ROUND_EN
    chk("lit_1p25", 64'(out), 64'd2);
`else
    chk("lit_1p25", 64'(out), 64'd1);
`endif
    run_op(32'h0001_8000, 1'b0, 0);
    chk("lit_1p5", 64'(out), 64'd2);
    run_op(32'hFFFF_0000, 1'b0, 0);
    chk("lit_ffff0000", 64'(out), 64'hFFFE_0001);
    run_op(32'hFFFF_FFFF, 1'b0, 0);
    chk("lit_ffffffff", 64'(out), 64'hFFFF_FFFE);
    run_op(32'h0000_0000, 1'b0, 0);
    run_op(32'h0003_0000, 1'b0, 10);
    run_op(32'h0002_0000, 1'b0, 0);
    chk("lit_2p0", 64'(out), 64'd4);

    // Abort mid-calculation with an asynchronous reset pulse.
    in = 32'h0003_0000;
    START = 1'b1;
    tick();
    repeat (15) tick();
    #2;
    rstn = 1'b1;
    #1;
    chk("abort_out", 64'(out), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    chk("abort_avail", 64'(AVAILABLE), 64'd1);
    START = 1'b0;
    tick();
    rstn = 1'b0;
    last_exp = '0;
    tick();
    run_op(32'h0001_0000, 1'b0, 0);
    chk("lit_1p0", 64'(out), 64'd1);

    run_op(32'h0003_0000, 1'b1, 2);
    for (int r = 0; r < 20; r++) begin
      run_op($urandom, 1'(r % 2), r % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
